packet_buffer_arbiter: RTL and testbench

Arbitrates the single read/write port of the packet buffer RAM between two requesters. The video path (graphics_main) reads one colour word per active pixel. The Ethernet path reads or writes packet words. Video has priority, so pixel fetch keeps its fixed latency; a starvation counter guarantees Ethernet forward progress by occasionally dropping a video slot. Each read response is routed back to its owner after exactly RAM_LATENCY cycles.

---
 rtl/packet_buffer_arbiter.sv | 80 ++++++++
 tb/tb_packet_buffer_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/packet_buffer_arbiter.sv
// packet_buffer_arbiter: shares the single packet buffer RAM port between video pixel reads and Ethernet accesses.
//   clk, reset                    : system clock, asynchronous active-high reset
//   vid_req/vid_addr              : video read request (no handshake, denied requests are lost)
//   vid_ready/vid_val/vid_drop    : video read response, data and denial pulse
//   eth_req/eth_we/eth_addr/eth_wdata : Ethernet access, held until eth_grant
//   eth_grant/eth_rvalid/eth_rdata: Ethernet acceptance and read response
//   ram_en/ram_we/ram_addr/ram_wdata/ram_rdata : RAM port
module packet_buffer_arbiter #(
   parameter int RAM_SIZE    = 1024,
   parameter int DATA_LEN    = 12,
   parameter int RAM_LATENCY = 2,
   parameter int MAX_STARVE  = 16,
   localparam int AW = $clog2(RAM_SIZE),
   localparam int SW = $clog2(MAX_STARVE + 1)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                vid_req,
   input  logic [AW-1:0]       vid_addr,
   output logic                vid_ready,
   output logic [DATA_LEN-1:0] vid_val,
   output logic                vid_drop,
   input  logic                eth_req,
   input  logic                eth_we,
   input  logic [AW-1:0]       eth_addr,
   input  logic [DATA_LEN-1:0] eth_wdata,
   output logic                eth_grant,
   output logic                eth_rvalid,
   output logic [DATA_LEN-1:0] eth_rdata,
   output logic                ram_en,
   output logic                ram_we,
   output logic [AW-1:0]       ram_addr,
   output logic [DATA_LEN-1:0] ram_wdata,
   input  logic [DATA_LEN-1:0] ram_rdata
);
   logic [SW-1:0]          r_starve;
   logic [RAM_LATENCY-1:0] r_valid;
   logic [RAM_LATENCY-1:0] r_owner;
   logic                   w_force;
   logic                   w_vid_take;
   logic                   w_rd;
   // Every issue-side output is gated by reset so the RAM sees nothing while reset is held.
   always_comb begin
      w_force    = !reset && eth_req && (r_starve == SW'(MAX_STARVE));
      eth_grant  = !reset && eth_req && (!vid_req || w_force);
      w_vid_take = !reset && vid_req && !w_force;
      vid_drop   = !reset && vid_req && w_force;
      ram_en     = w_vid_take || eth_grant;
      ram_we     = eth_grant && eth_we;
      ram_addr   = reset ? '0 : (w_vid_take ? vid_addr : eth_addr);
      ram_wdata  = reset ? '0 : eth_wdata;
      w_rd       = w_vid_take || (eth_grant && !eth_we);
      vid_ready  = r_valid[RAM_LATENCY-1] && !r_owner[RAM_LATENCY-1];
      eth_rvalid = r_valid[RAM_LATENCY-1] && r_owner[RAM_LATENCY-1];
      vid_val    = vid_ready ? ram_rdata : '0;
      eth_rdata  = eth_rvalid ? ram_rdata : '0;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_starve <= '0;
      else if (eth_grant || !eth_req)
         r_starve <= '0;
      else if (r_starve != SW'(MAX_STARVE))
         r_starve <= r_starve + 1'b1;
   end
   // Owner bit: 1 = Ethernet, 0 = video; meaningful only alongside its valid bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_valid <= '0;
         r_owner <= '0;
      end else begin
         r_valid[0] <= w_rd;
         r_owner[0] <= !w_vid_take;
         for (int k = 1; k < RAM_LATENCY; k++) begin
            r_valid[k] <= r_valid[k-1];
            r_owner[k] <= r_owner[k-1];
         end
      end
   end
endmodule

// File: tb/tb_packet_buffer_arbiter.sv
// tb_packet_buffer_arbiter: directed self-checking bench with a two-cycle RAM model.
module tb_packet_buffer_arbiter;
   localparam int AW = 10;
   localparam int DW = 12;
   logic          clk = 0;
   logic          reset = 1;
   logic          vid_req = 0, eth_req = 0, eth_we = 0;
   logic [AW-1:0] vid_addr = '0, eth_addr = '0;
   logic [DW-1:0] eth_wdata = '0;
   logic          vid_ready, vid_drop, eth_grant, eth_rvalid, ram_en, ram_we;
   logic [DW-1:0] vid_val, eth_rdata, ram_wdata, ram_rdata;
   logic [AW-1:0] ram_addr;
   logic          pre_we = 0;
   logic [AW-1:0] pre_addr = '0;
   logic [DW-1:0] pre_data = '0;
   logic [DW-1:0] mem [1024];
   logic [DW-1:0] d1, d2;
   int            checks = 0;
   int            failures = 0;

   packet_buffer_arbiter #(.RAM_SIZE(1024), .DATA_LEN(DW), .RAM_LATENCY(2), .MAX_STARVE(16)) dut (
      .clk(clk), .reset(reset),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_ready(vid_ready), .vid_val(vid_val), .vid_drop(vid_drop),
      .eth_req(eth_req), .eth_we(eth_we), .eth_addr(eth_addr), .eth_wdata(eth_wdata),
      .eth_grant(eth_grant), .eth_rvalid(eth_rvalid), .eth_rdata(eth_rdata),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata));

   always #5 clk = ~clk;

   assign ram_rdata = d2;
   always @(posedge clk) begin
      if (pre_we) mem[pre_addr] <= pre_data;
      else if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
      if (ram_en && !ram_we) d1 <= mem[ram_addr];
      d2 <= d1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
      pre_we = 1; pre_addr = a; pre_data = d;
      step();
      pre_we = 0;
   endtask

   task automatic idle();
      vid_req = 0; eth_req = 0; eth_we = 0;
   endtask

   task automatic test_reset();
      vid_req = 1; vid_addr = 5; eth_req = 1; eth_addr = 7;
      #1;
      checks++; if (ram_en !== 0) begin failures++; $display("FAIL reset_ram_en got %0b want 0", ram_en); end
      checks++; if (eth_grant !== 0) begin failures++; $display("FAIL reset_eth_grant got %0b want 0", eth_grant); end
      checks++; if (vid_drop !== 0) begin failures++; $display("FAIL reset_vid_drop got %0b want 0", vid_drop); end
      checks++; if (vid_ready !== 0 || eth_rvalid !== 0) begin failures++; $display("FAIL reset_valid got %0b%0b want 00", vid_ready, eth_rvalid); end
      idle();
      #2 reset = 0;
      step();
   endtask

   task automatic test_video();
      vid_req = 1; vid_addr = 5;
      #1;
      checks++; if (ram_en !== 1 || ram_we !== 0 || ram_addr !== 10'd5) begin failures++; $display("FAIL vid_issue got en=%0b we=%0b addr=%0d want 1 0 5", ram_en, ram_we, ram_addr); end
      step(); idle(); #1;
      checks++; if (vid_ready !== 0 || vid_val !== 0) begin failures++; $display("FAIL vid_early got %0b %h want 0 000", vid_ready, vid_val); end
      step();
      checks++; if (vid_ready !== 1 || vid_val !== 12'hABC || eth_rvalid !== 0) begin failures++; $display("FAIL vid_resp got %0b %h %0b want 1 abc 0", vid_ready, vid_val, eth_rvalid); end
      step();
      checks++; if (vid_ready !== 0 || vid_val !== 0) begin failures++; $display("FAIL vid_after got %0b %h want 0 000", vid_ready, vid_val); end
   endtask

   task automatic test_eth_write_read();
      eth_req = 1; eth_we = 1; eth_addr = 7; eth_wdata = 12'h123;
      #1;
      checks++; if (eth_grant !== 1 || ram_we !== 1 || ram_en !== 1 || ram_addr !== 10'd7 || ram_wdata !== 12'h123) begin failures++; $display("FAIL eth_write got g=%0b we=%0b en=%0b a=%0d d=%h want 1 1 1 7 123", eth_grant, ram_we, ram_en, ram_addr, ram_wdata); end
      step(); eth_we = 0; #1;
      checks++; if (eth_grant !== 1 || ram_we !== 0 || ram_addr !== 10'd7) begin failures++; $display("FAIL eth_read_issue got g=%0b we=%0b a=%0d want 1 0 7", eth_grant, ram_we, ram_addr); end
      step(); idle(); #1;
      checks++; if (eth_rvalid !== 0) begin failures++; $display("FAIL eth_write_noresp got %0b want 0", eth_rvalid); end
      step();
      checks++; if (eth_rvalid !== 1 || eth_rdata !== 12'h123 || vid_ready !== 0) begin failures++; $display("FAIL eth_read_resp got %0b %h %0b want 1 123 0", eth_rvalid, eth_rdata, vid_ready); end
      step();
   endtask

   task automatic test_starvation();
      int n;
      vid_req = 1; vid_addr = 1; eth_req = 1; eth_we = 0; eth_addr = 2;
      #1;
      n = 0;
      while (!eth_grant && n < 40) begin
         checks++; if (vid_drop !== 0 || ram_addr !== 10'd1) begin failures++; $display("FAIL starve_deny%0d got drop=%0b addr=%0d want 0 1", n, vid_drop, ram_addr); end
         n++; step();
      end
      checks++; if (n !== 16) begin failures++; $display("FAIL starve_count got %0d want 16", n); end
      checks++; if (eth_grant !== 1 || vid_drop !== 1 || ram_addr !== 10'd2) begin failures++; $display("FAIL starve_force got g=%0b drop=%0b a=%0d want 1 1 2", eth_grant, vid_drop, ram_addr); end
      step();
      checks++; if (eth_grant !== 0 || vid_drop !== 0 || vid_ready !== 1 || vid_val !== 12'h111) begin failures++; $display("FAIL starve_next got g=%0b drop=%0b r=%0b v=%h want 0 0 1 111", eth_grant, vid_drop, vid_ready, vid_val); end
      step();
      checks++; if (vid_ready !== 0 || eth_rvalid !== 1 || eth_rdata !== 12'h222) begin failures++; $display("FAIL starve_slot got r=%0b e=%0b d=%h want 0 1 222", vid_ready, eth_rvalid, eth_rdata); end
      n = 1;
      while (!eth_grant && n < 40) begin n++; step(); end
      checks++; if (n !== 16 || vid_drop !== 1) begin failures++; $display("FAIL starve_rearm got %0d drop=%0b want 16 1", n, vid_drop); end
      step(); idle(); step(); step(); step();
   endtask

   task automatic test_back_to_back();
      logic [AW-1:0] addr [4];
      logic [DW-1:0] data [4];
      addr = '{10, 11, 12, 13};
      data = '{12'hA0A, 12'hB1B, 12'hC2C, 12'hD3D};
      for (int c = 0; c < 6; c++) begin
         idle();
         if (c < 4) begin
            vid_req = (c % 2 == 0); vid_addr = addr[c];
            eth_req = (c % 2 == 1); eth_addr = addr[c];
         end
         #1;
         if (c < 4) begin
            checks++; if (ram_en !== 1 || ram_addr !== addr[c] || eth_grant !== (c % 2 == 1)) begin failures++; $display("FAIL b2b_issue%0d got en=%0b a=%0d g=%0b", c, ram_en, ram_addr, eth_grant); end
         end
         if (c >= 2) begin
            checks++; if (vid_ready !== (c % 2 == 0) || eth_rvalid !== (c % 2 == 1) || ram_rdata !== data[c-2] || (vid_val | eth_rdata) !== data[c-2]) begin failures++; $display("FAIL b2b_resp%0d got r=%0b e=%0b v=%h d=%h want data %h", c, vid_ready, eth_rvalid, vid_val, eth_rdata, data[c-2]); end
         end
         step();
      end
   endtask

   task automatic test_async_reset();
      vid_req = 1; vid_addr = 5;
      step(); idle(); eth_req = 1; eth_addr = 7;
      step(); idle(); #1;
      checks++; if (vid_ready !== 1) begin failures++; $display("FAIL arst_pre got %0b want 1", vid_ready); end
      #1 reset = 1;
      #1;
      checks++; if (vid_ready !== 0 || eth_rvalid !== 0 || vid_val !== 0 || eth_rdata !== 0) begin failures++; $display("FAIL arst_now got r=%0b e=%0b v=%h d=%h want 0 0 000 000", vid_ready, eth_rvalid, vid_val, eth_rdata); end
      step(); step();
      #2 reset = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++; if (vid_ready !== 0 || eth_rvalid !== 0) begin failures++; $display("FAIL arst_stale%0d got %0b%0b want 00", i, vid_ready, eth_rvalid); end
      end
   endtask

   task automatic test_starve_restart();
      int n;
      vid_req = 1; vid_addr = 1; eth_req = 1; eth_we = 0; eth_addr = 2;
      for (int i = 0; i < 10; i++) begin
         #1;
         checks++; if (eth_grant !== 0) begin failures++; $display("FAIL restart_deny%0d got %0b want 0", i, eth_grant); end
         step();
      end
      eth_req = 0;
      #1;
      checks++; if (eth_grant !== 0 || vid_drop !== 0) begin failures++; $display("FAIL restart_gap got g=%0b drop=%0b want 0 0", eth_grant, vid_drop); end
      step();
      eth_req = 1;
      #1;
      n = 0;
      while (!eth_grant && n < 40) begin n++; step(); end
      checks++; if (n !== 16 || vid_drop !== 1) begin failures++; $display("FAIL restart_force got %0d drop=%0b want 16 1", n, vid_drop); end
      step(); idle(); step();
   endtask

   task automatic test_blanking();
      eth_req = 1; eth_we = 0;
      for (int i = 0; i < 20; i++) begin
         eth_addr = AW'(i);
         #1;
         checks++; if (eth_grant !== 1 || vid_drop !== 0) begin failures++; $display("FAIL blank_grant%0d got %0b want 1", i, eth_grant); end
         step();
      end
      idle(); step(); step();
   endtask

   initial begin
      preload(1, 12'h111);
      preload(2, 12'h222);
      preload(5, 12'hABC);
      preload(10, 12'hA0A);
      preload(11, 12'hB1B);
      preload(12, 12'hC2C);
      preload(13, 12'hD3D);
      test_reset();
      test_video();
      test_eth_write_read();
      test_starvation();
      test_back_to_back();
      test_async_reset();
      test_starve_restart();
      test_blanking();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got no finish want finish");
      $fatal(1, "timeout");
   end
endmodule
